mem_responder: RTL

Single-port memory responder for the core's `req`/`gnt` memory interface, acting as the target end of the interface the core initiates on. It is instantiated once per port (imem, dmem) in simulation and formal testbenches. Each instance is a byte-strobed RAM with:
- a fixed response latency, plus optional pseudo-random extra stall;
- an error response for addresses outside the RAM window;
- a sticky flag for requester protocol violations.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Memory request/grant bus between a requester (master) and a responder (slave).
interface mem_responder_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    input  mem_gnt, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    output mem_gnt, mem_err, mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-strobed single-port RAM responder with fixed latency, optional LFSR stall,
// out-of-window error response and a sticky requester protocol-violation flag.
module mem_responder #(
  parameter logic [63:0] RAM_BASE  = 64'h0,
  parameter int unsigned DEPTH_W   = 10,
  parameter int unsigned LATENCY   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic           g_clk,
  input  logic           g_reset,
  input  logic           rand_en,
  mem_responder_if.slave bus,
  output logic           proto_err
);

  localparam logic [63:0] WindowBytes = 64'd8 << DEPTH_W;
  localparam int unsigned Words       = 1 << DEPTH_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [7:0]           lfsr_q;
  logic                 proto_err_q;
  logic [63:0]          addr_q;
  logic [63:0]          wdata_q;
  logic [7:0]           strb_q;
  logic                 wen_q;
  logic                 in_range_q;
  logic [63:0]          ram_q [Words];

  logic [7:0]           lfsr_next;
  logic [63:0]          addr_off;
  logic                 in_range;
  logic [3:0]           cnt_init;
  logic                 req_mismatch;
  logic [DEPTH_W-1:0]   word_idx;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
  assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  assign addr_off = bus.mem_addr - RAM_BASE;
  assign in_range = (bus.mem_addr >= RAM_BASE) && (addr_off < WindowBytes);
  assign cnt_init = 4'(LATENCY - 1) + (rand_en ? {2'b00, lfsr_q[1:0]} : 4'd0);

  // Any drop of req or change of the held request while waiting is a violation.
  assign req_mismatch = !bus.mem_req || (bus.mem_addr != addr_q) || (bus.mem_wen != wen_q) ||
                        (bus.mem_strb != strb_q) || (bus.mem_wdata != wdata_q);

  // Index uses absolute address bits; the window check alone decides validity.
  assign word_idx = addr_q[DEPTH_W+2:3];

  // Request FSM: accept in idle, count down latency, respond for one cycle.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      lfsr_q      <= LFSR_SEED;
      proto_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      wen_q       <= 1'b0;
      in_range_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next;
      unique case (state_q)
        StIdle: begin
          if (bus.mem_req) begin
            addr_q     <= bus.mem_addr;
            wdata_q    <= bus.mem_wdata;
            strb_q     <= bus.mem_strb;
            wen_q      <= bus.mem_wen;
            in_range_q <= in_range;
            cnt_q      <= cnt_init;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (req_mismatch) proto_err_q <= 1'b1;
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM write commits on the response edge so a later read sees it.
  always_ff @(posedge g_clk) begin
    if (!g_reset && (state_q == StResp) && wen_q && in_range_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) ram_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_gnt   = (state_q == StResp);
  assign bus.mem_err   = (state_q == StResp) && !in_range_q;
  assign bus.mem_rdata = ((state_q == StResp) && in_range_q && !wen_q) ? ram_q[word_idx] : '0;
  assign proto_err     = proto_err_q;

endmodule
